// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES encryption core.
package aes_pkg;

    localparam int NR_128   = 10;
    localparam int NR_192   = 12;
    localparam int NR_256   = 14;
    localparam int KS_W_DEF = 2048;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    function automatic logic [3:0] nr_from_nk(input int unsigned nk);
        if (nk == 4)
            return 4'(NR_128);
        else if (nk == 6)
            return 4'(NR_192);
        else
            return 4'(NR_256);
    endfunction

    // Round key r sits at the MSB end; only indices 0..14 are ever selected.
    function automatic logic [127:0] rk_slice(input logic [KS_W_DEF-1:0] ks, input logic [3:0] r);
        logic [127:0] rk;
        rk = '0;
        for (int i = 0; i < 15; i++)
            if (r == 4'(i))
                rk = ks[KS_W_DEF-1-128*i -: 128];
        return rk;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i])
                p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return 8'((x << k) | (x >> (8 - k)));
    endfunction

    // S-box as multiplicative inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gmul(a, a);
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            inv = gmul(inv, sq);
            sq  = gmul(sq, sq);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] state_out
);

    // Byte i of the block is row i%4, column i/4, byte 0 at the MSBs.
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sb        = '{default: '0};
        sr        = '{default: '0};
        mc        = '{default: '0};
        state_out = '0;

        for (int i = 0; i < 16; i++)
            sb[i] = sbox(state_in[127-8*i -: 8]);

        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[r+4*c] = sb[r+4*((c+r)%4)];

        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end

        for (int i = 0; i < 16; i++)
            state_out[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
    end

endmodule

// File: rtl/aes_round_scheduler.sv
// Iterative AES encryptor: one round per clock through a shared round datapath,
// job accepted and result returned over valid/ready handshakes.
module aes_round_scheduler
    import aes_pkg::*;
#(
    parameter int KS_W = KS_W_DEF,
    parameter int NK_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [127:0]    word,
    input  logic [NK_W-1:0] nk,
    input  logic [KS_W-1:0] key_sched,
    output logic            done_valid,
    input  logic            done_ready,
    output logic [127:0]    wordout,
    output logic            busy
);

    fsm_t         fsm;
    logic [127:0] state;
    logic [3:0]   round;
    logic [3:0]   nr;
    logic [127:0] rk;
    logic [127:0] rk0;
    logic [127:0] next_state;
    logic         last;

    // key_sched is used live, not latched; the source holds it for the whole job.
    assign rk   = rk_slice(key_sched, round);
    assign rk0  = rk_slice(key_sched, 4'd0);
    assign last = (round == nr);

    aes_round_comb u_round (
        .state_in  (state),
        .rk        (rk),
        .last      (last),
        .state_out (next_state)
    );

    // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            state       <= '0;
            round       <= '0;
            nr          <= '0;
            start_ready <= 1'b0;
            done_valid  <= 1'b0;
            wordout     <= '0;
            busy        <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    start_ready <= 1'b1;
                    if (start_valid && start_ready) begin
                        state       <= word ^ rk0;
                        round       <= 4'd1;
                        nr          <= nr_from_nk(int'(nk));
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        fsm         <= RUN;
                    end
                end
                RUN: begin
                    state <= next_state;
                    if (last) begin
                        wordout    <= next_state;
                        done_valid <= 1'b1;
                        fsm        <= DONE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                DONE: begin
                    // start_ready stays low here, so no accept can coincide with the handshake.
                    if (done_ready) begin
                        done_valid  <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                        fsm         <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Self-checking bench: FIPS-197 vectors plus random jobs against a byte-array AES model.
module tb_aes_round_scheduler;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [127:0]  word;
    logic [3:0]    nk;
    logic [2047:0] key_sched;
    logic          done_valid;
    logic          done_ready;
    logic [127:0]  wordout;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_q[$];
    logic [7:0]    sb_t [256];
    logic [2047:0] ks_prev = '0;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_round_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .word        (word),
        .nk          (nk),
        .key_sched   (key_sched),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .wordout     (wordout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && start_valid && start_ready)
            acc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    // The key schedule must stay put from accept until the result is taken.
    always @(posedge clk) begin
        if (busy && key_sched !== ks_prev)
            $error("key_sched changed while the job was running");
        ks_prev <= key_sched;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rl(input logic [7:0] x, input int k);
        return 8'((x << k) | (x >> (8 - k)));
    endfunction

    // S-box built by walking generator 3 and its inverse together.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7])
                q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
    endfunction

    function automatic logic [2047:0] expand(input logic [255:0] key, input int nkw);
        logic [31:0]   w [60];
        logic [31:0]   temp;
        logic [7:0]    rcon;
        logic [2047:0] ks;
        int            total_w;
        total_w = 4 * (nkw + 7);
        rcon    = 8'h01;
        ks      = '0;
        for (int i = 0; i < nkw; i++)
            w[i] = key[255-32*i -: 32];
        for (int i = nkw; i < total_w; i++) begin
            temp = w[i-1];
            if (i % nkw == 0) begin
                temp = subw({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else if (nkw > 6 && i % nkw == 4) begin
                temp = subw(temp);
            end
            w[i] = w[i-nkw] ^ temp;
        end
        for (int i = 0; i < total_w; i++)
            ks[2047-32*i -: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input int k);
        logic [7:0] a2;
        a2 = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        return (k == 2) ? a2 : (a2 ^ a);
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [2047:0] ks, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] rk;
        logic [127:0] ct;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8];
        for (int rnd = 0; rnd <= nr; rnd++) begin
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        t[r][c] = sb_t[s[(r)][(c+r)%4]];
                s = t;
                if (rnd < nr) begin
                    for (int c = 0; c < 4; c++) begin
                        t[0][c] = gm(s[0][c], 2) ^ gm(s[1][c], 3) ^ s[2][c] ^ s[3][c];
                        t[1][c] = s[0][c] ^ gm(s[1][c], 2) ^ gm(s[2][c], 3) ^ s[3][c];
                        t[2][c] = s[0][c] ^ s[1][c] ^ gm(s[2][c], 2) ^ gm(s[3][c], 3);
                        t[3][c] = gm(s[0][c], 3) ^ s[1][c] ^ s[2][c] ^ gm(s[3][c], 2);
                    end
                    s = t;
                end
            end
            rk = ks[2047-128*rnd -: 128];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = s[r][c] ^ rk[127-8*(4*c+r) -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                ct[127-8*(4*c+r) -: 8] = s[r][c];
        return ct;
    endfunction

    function automatic int nk_words(input logic [3:0] n);
        return (n == 4'd4) ? 4 : (n == 4'd6) ? 6 : 8;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++)
            k[32*i +: 32] = $urandom;
        return k;
    endfunction

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_job(input logic [127:0] w, input logic [255:0] key, input logic [3:0] nk_v,
                           input int hold, input bit disturb, input bit has_ref, input logic [127:0] ref_ct);
        int           nkw;
        int           t0;
        int           n_acc;
        bit           ok;
        bit           stable;
        logic [127:0] exp_ct;
        nkw = nk_words(nk_v);
        @(negedge clk);
        key_sched   = expand(key, nkw);
        exp_ct      = encrypt(w, key_sched, nkw + 6);
        word        = w;
        nk          = nk_v;
        start_valid = 1'b1;
        done_ready  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (start_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_wait", 128'(ok), 128'(1));
        if (!ok) begin
            start_valid = 1'b0;
            return;
        end
        t0    = cyc;
        n_acc = acc_q.size();
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        word        = rand_word();
        nk          = 4'($urandom);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_valid) begin
                ok = 1'b1;
                break;
            end
            if (disturb) begin
                start_valid = 1'($urandom);
                nk          = 4'($urandom);
            end
        end
        start_valid = 1'b0;
        check("done_wait", 128'(ok), 128'(1));
        check("latency", 128'(cyc - t0), 128'(nkw + 7));
        if (disturb)
            check("no_reaccept", 128'(acc_q.size()), 128'(n_acc + 1));
        check("ct_model", wordout, exp_ct);
        if (has_ref)
            check("ct_fips", wordout, ref_ct);
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!(done_valid && wordout === exp_ct && !start_ready && busy))
                    stable = 1'b0;
            end
            check("hold_stable", 128'(stable), 128'(1));
        end
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        @(negedge clk);
        check("dv_clear", 128'(done_valid), 128'(0));
        check("idle_ready", 128'(start_ready), 128'(1));
        check("busy_clear", 128'(busy), 128'(0));
        check("wordout_keep", wordout, exp_ct);
    endtask

    initial begin
        logic [127:0] bw [3];
        logic [255:0] bk [3];
        logic [3:0]   rnk;
        int           base;
        bit           ok;
        bit           quiet;

        build_sbox();
        rst         = 1'b1;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        word        = '0;
        nk          = '0;
        key_sched   = '0;

        repeat (3) @(negedge clk);
        check("rst_start_ready", 128'(start_ready), 128'(0));
        check("rst_done_valid", 128'(done_valid), 128'(0));
        check("rst_wordout", wordout, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 128'(start_ready), 128'(1));

        run_job(PT, KEY128, 4'd4, 0, 1'b0, 1'b1, CT128);
        run_job(PT, KEY192, 4'd6, 0, 1'b0, 1'b1, CT192);
        run_job(PT, KEY256, 4'd8, 0, 1'b0, 1'b1, CT256);
        run_job(PT, KEY256, 4'd5, 0, 1'b0, 1'b1, CT256);
        run_job(PT, KEY128, 4'd4, 20, 1'b0, 1'b1, CT128);
        run_job(PT, KEY192, 4'd6, 0, 1'b1, 1'b1, CT192);

        // Abort a running job with a reset pulse.
        @(negedge clk);
        key_sched   = expand(KEY128, 4);
        word        = PT;
        nk          = 4'd4;
        start_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (start_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_job_accept", 128'(ok), 128'(1));
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_ready", 128'(start_ready), 128'(0));
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_valid || wordout !== 128'(0))
                quiet = 1'b0;
        end
        check("midrst_no_done", 128'(quiet), 128'(1));
        check("midrst_ready_after", 128'(start_ready), 128'(1));

        // Back-to-back AES-128 jobs with the consumer always ready.
        for (int j = 0; j < 3; j++) begin
            bw[j] = rand_word();
            bk[j] = rand_key();
        end
        base = acc_q.size();
        done_ready  = 1'b1;
        key_sched   = expand(bk[0], 4);
        word        = bw[0];
        nk          = 4'd4;
        start_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("b2b_done_wait", 128'(ok), 128'(1));
            check("b2b_ct", wordout, encrypt(bw[j], expand(bk[j], 4), 10));
            @(negedge clk);
            if (j < 2) begin
                key_sched = expand(bk[j+1], 4);
                word      = bw[j+1];
            end else begin
                start_valid = 1'b0;
            end
        end
        done_ready = 1'b0;
        check("b2b_accepts", 128'(acc_q.size() - base), 128'(3));
        if (acc_q.size() - base == 3) begin
            check("b2b_gap0", 128'(acc_q[base+1] - acc_q[base]), 128'(12));
            check("b2b_gap1", 128'(acc_q[base+2] - acc_q[base+1]), 128'(12));
        end

        for (int n = 0; n < 8; n++) begin
            case ($urandom % 4)
                0:       rnk = 4'd4;
                1:       rnk = 4'd6;
                2:       rnk = 4'd8;
                default: rnk = 4'($urandom);
            endcase
            run_job(rand_word(), rand_key(), rnk, int'($urandom % 4), 1'($urandom), 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
